// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-requester round-robin arbiter with hold limit
// Registered one-hot grant with encoded index and forced-rotation timeout pulse.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_req,
  input  logic       i_done,
  output logic [3:0] o_gnt,
  output logic [1:0] o_gnt_id,
  output logic       o_gnt_valid,
  output logic       o_timeout
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;
  logic [3:0]       r_gnt, w_gnt_nxt;
  logic [1:0]       r_gnt_id, w_gnt_id_nxt;
  logic             r_timeout, w_timeout_nxt;

  logic             w_at_limit;
  logic             w_others_wait;
  logic             w_rel_vol;
  logic             w_rel_limit;
  logic             w_release;
  logic [1:0]       w_rel_ptr;
  logic [2:0]       w_pick_idle;
  logic [2:0]       w_pick_rel;

  // Returns {found, index}; scanning from the highest offset down lets the
  // bit closest to ptr overwrite later candidates and win.
  function automatic logic [2:0] f_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_at_limit    = (r_hold_cnt == CNT_W'(MAX_HOLD));
  assign w_others_wait = |(i_req & ~r_gnt);
  assign w_rel_vol     = i_done | ~i_req[r_gnt_id];
  assign w_rel_limit   = w_at_limit & w_others_wait;
  assign w_release     = w_rel_vol | w_rel_limit;
  assign w_rel_ptr     = r_gnt_id + 2'd1;
  assign w_pick_idle   = f_pick(i_req, r_ptr);
  assign w_pick_rel    = f_pick(i_req, w_rel_ptr);

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_idle[2]) begin
          w_state_nxt  = S_GRANT;
          w_gnt_nxt    = 4'b0001 << w_pick_idle[1:0];
          w_gnt_id_nxt = w_pick_idle[1:0];
          w_hold_nxt   = CNT_W'(1);
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_ptr_nxt     = w_rel_ptr;
          w_timeout_nxt = w_rel_limit & ~w_rel_vol;
          if (w_pick_rel[2]) begin
            w_gnt_nxt    = 4'b0001 << w_pick_rel[1:0];
            w_gnt_id_nxt = w_pick_rel[1:0];
            w_hold_nxt   = CNT_W'(1);
          end else begin
            w_state_nxt  = S_IDLE;
            w_gnt_nxt    = 4'b0000;
            w_gnt_id_nxt = 2'd0;
            w_hold_nxt   = '0;
          end
        end else if (!w_at_limit) begin
          w_hold_nxt = r_hold_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= 2'd0;
      r_hold_cnt <= '0;
      r_gnt      <= 4'b0000;
      r_gnt_id   <= 2'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_id    = r_gnt_id;
  assign o_gnt_valid = |r_gnt;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - scoreboard bench for rr_arbiter_4 with MAX_HOLD=4
module tb_rr_arbiter_4;

  localparam int MH = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [3:0] i_req;
  logic       i_done;
  logic [3:0] o_gnt;
  logic [1:0] o_gnt_id;
  logic       o_gnt_valid;
  logic       o_timeout;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] q_exp[$];

  bit m_valid;
  int m_g, m_ptr, m_hold;

  rr_arbiter_4 #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req),
    .i_done     (i_done),
    .o_gnt      (o_gnt),
    .o_gnt_id   (o_gnt_id),
    .o_gnt_valid(o_gnt_valid),
    .o_timeout  (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got gnt=%b id=%0d v=%b to=%b, want gnt=%b id=%0d v=%b to=%b",
               tag, obs[7:4], obs[3:2], obs[1], obs[0], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [7:0] obs_now();
    return {o_gnt, o_gnt_id, o_gnt_valid, o_timeout};
  endfunction

  // Expected output word {gnt, id, valid, timeout} from a one-hot grant.
  function automatic logic [7:0] mk(input logic [3:0] g, input logic to);
    logic [1:0] id;
    case (g)
      4'b0010: id = 2'd1;
      4'b0100: id = 2'd2;
      4'b1000: id = 2'd3;
      default: id = 2'd0;
    endcase
    return {g, id, |g, to};
  endfunction

  function automatic int pick_first(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++)
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] req, input logic done, output logic [7:0] exp);
    logic to;
    bit rel_v, rel_c;
    int w;
    to = 1'b0;
    if (!m_valid) begin
      w = pick_first(req, m_ptr);
      if (w >= 0) begin m_valid = 1; m_g = w; m_hold = 1; end
    end else begin
      rel_v = done || !req[m_g];
      rel_c = (m_hold == MH) && ((req & ~(4'b0001 << m_g)) != 4'b0);
      if (rel_v || rel_c) begin
        to    = rel_c && !rel_v;
        m_ptr = (m_g + 1) % 4;
        w     = pick_first(req, m_ptr);
        if (w >= 0) begin m_g = w; m_hold = 1; end
        else begin m_valid = 0; m_hold = 0; end
      end else if (m_hold < MH) begin
        m_hold++;
      end
    end
    exp = mk(m_valid ? (4'b0001 << m_g) : 4'b0000, to);
  endtask

  task automatic step(input logic [3:0] req, input logic done, input logic [7:0] exp,
                      input string tag);
    i_req  = req;
    i_done = done;
    q_exp.push_back(exp);
    @(posedge i_clk);
    #1;
    chk(tag, obs_now(), q_exp.pop_front());
  endtask

  task automatic do_reset(input logic [3:0] req);
    i_rst_n = 1'b0;
    i_req   = req;
    i_done  = 1'b0;
    #2;
    chk("in_reset", obs_now(), 8'h00);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    m_valid = 0; m_ptr = 0; m_hold = 0; m_g = 0;
  endtask

  initial begin
    logic [7:0] e;
    logic [3:0] r;
    logic       d;

    do_reset(4'b1111);
    step(4'b1111, 1'b0, mk(4'b0001, 1'b0), "reset_first_grant");

    do_reset(4'b0000);
    step(4'b0100, 1'b0, mk(4'b0100, 1'b0), "single_req2");
    step(4'b0000, 1'b0, mk(4'b0000, 1'b0), "single_drop");
    step(4'b1111, 1'b0, mk(4'b1000, 1'b0), "ptr_after_drop");

    do_reset(4'b0000);
    for (int k = 0; k < 6; k++)
      step(4'b1111, 1'b1, mk(4'b0001 << (k % 4), 1'b0), "fair_rotate");

    do_reset(4'b0000);
    for (int k = 0; k < 16; k++)
      step(4'b0011, 1'b0, mk(((k / MH) % 2) ? 4'b0010 : 4'b0001, (k >= MH) && (k % MH == 0)),
           "hold_limit");

    do_reset(4'b0000);
    for (int k = 0; k < 20; k++)
      step(4'b0001, 1'b0, mk(4'b0001, 1'b0), "lone_req");

    do_reset(4'b0000);
    for (int k = 0; k < MH; k++)
      step(4'b0011, 1'b0, mk(4'b0001, 1'b0), "pre_simul");
    step(4'b0011, 1'b1, mk(4'b0010, 1'b0), "simul_done_limit");
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("async_reset_mid", obs_now(), 8'h00);
    @(posedge i_clk);
    #1;
    chk("held_in_reset", obs_now(), 8'h00);

    do_reset(4'b0000);
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 7) == 0);
      model_step(r, d, e);
      step(r, d, e, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that shares a single downstream resource, such as a 4:2 encoder path or shared bus.
- Produces a registered one-hot grant and its 2-bit encoded index.
- The grantee holds the grant until it signals done, drops its request, or exceeds a hold limit while others wait.
- Sits between four request sources and the shared resource's select/mux input.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles while another requester is waiting. Legal range 1..255.
- CNT_W, 8, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request per requester; bit i = requester i
- done  input  1  current grantee finished; sampled only while gnt_valid=1
- gnt  output  4  one-hot grant, registered; all-zero when idle
- gnt_id  output  2  binary index of the set gnt bit; 0 when gnt_valid=0
- gnt_valid  output  1  high when any gnt bit is set
- timeout  output  1  one-cycle pulse marking a forced rotation by hold limit

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n). Assertion clears all state immediately, regardless of clock.
- Reset values:
  - gnt=0000, gnt_id=00, gnt_valid=0, timeout=0
  - priority pointer ptr=0
  - hold_cnt=0
  - state=IDLE
- State machine: two states, IDLE and GRANT.
- IDLE:
  - If req!=0, grant on the next edge to the first set bit scanning ptr, ptr+1, ... mod 4; go to GRANT with hold_cnt=1.
  - Latency from req sampled high to gnt high: 1 cycle.
- GRANT release conditions, checked each edge, with current grantee g:
  - (a) done=1
  - (b) req[g]=0
  - (c) hold_cnt==MAX_HOLD and (req & ~gnt)!=0
- On release:
  - ptr <= g+1 mod 4.
  - Arbitrate in the same edge over the sampled req using the new ptr; g itself therefore has lowest priority.
  - If any req is set, grant the winner with hold_cnt=1 and stay in GRANT. There is no idle gap between back-to-back grants.
  - If req=0, clear gnt and go to IDLE.
- No release: hold gnt unchanged; hold_cnt increments, saturating at MAX_HOLD.
  - A lone requester keeps the grant indefinitely, with no timeout.
- timeout:
  - Registered; high for exactly the one cycle following a release caused only by (c).
  - If (a) or (b) holds in the same cycle as (c), timeout=0. Voluntary release has priority.
- Output invariants:
  - gnt is always zero or one-hot.
  - gnt_id = encode(gnt); gnt_valid = |gnt. All three are registered together, with no combinational path from req.
- The arbiter never grants a requester whose req bit is 0 in the cycle the decision is made.
- MAX_HOLD=1: each grant lasts exactly 1 cycle under contention, giving strict per-cycle rotation.
- Reset asserted mid-grant: gnt drops asynchronously and ptr returns to 0. After deassertion the arbiter resumes from IDLE.

Test Plan:
- Reset with req=1111 held:
  - While rst_n=0: all outputs 0.
  - First edge after rst_n=1: gnt=0001, gnt_id=0, gnt_valid=1.
- Single request:
  - req=0100 -> next cycle gnt=0100, gnt_id=2.
  - Drop req[2] -> next cycle gnt=0000, gnt_valid=0.
  - Then req=1111 -> gnt=1000, since ptr=3.
- Fairness: req=1111 held, done=1 every cycle -> grant sequence 0,1,2,3,0,1 on consecutive cycles; gnt_valid stays 1; timeout stays 0.
- Hold limit: MAX_HOLD=4, req=0011 held, done=0:
  - gnt=0001 for 4 cycles, then gnt=0010 for 4 cycles, alternating.
  - timeout=1 on the first cycle of each new grant.
- Lone requester: req=0001 held 20 cycles, done=0 -> gnt=0001 throughout; timeout never asserts.
- Simultaneous release and async reset:
  - MAX_HOLD=4, req=0011, done=1 in the cycle hold_cnt=4 -> grant moves to 1 with timeout=0.
  - Assert rst_n=0 mid-cycle -> gnt=0000 before the next edge.
